// File: rtl/alu_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_unit_pkg
// Purpose  : Op and state encodings shared by the ALU execution unit.
// Revision : 1.0 - initial release
// ============================================================================
package alu_unit_pkg;

    localparam int c_op_width = 5;

    typedef enum logic [c_op_width-1:0] {
        OP_ADD    = 5'd0,
        OP_ADDC   = 5'd1,
        OP_SUB    = 5'd2,
        OP_SUBC   = 5'd3,
        OP_INC    = 5'd4,
        OP_DEC    = 5'd5,
        OP_CARRY  = 5'd6,
        OP_BORROW = 5'd7,
        OP_ADDZ   = 5'd8,
        OP_AND    = 5'd9,
        OP_OR     = 5'd10,
        OP_XOR    = 5'd11,
        OP_LSL    = 5'd12,
        OP_LSR    = 5'd13,
        OP_ASR    = 5'd14,
        OP_CSL    = 5'd15,
        OP_CSR    = 5'd16,
        OP_MUL    = 5'd17
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_shift_step.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_step
// Purpose  : Combinational single-step shifter/rotator for the ALU unit.
// Revision : 1.0 - initial release
// ============================================================================
module alu_shift_step
    import alu_unit_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int AMT_W      = $clog2(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0] i_value,
    input  alu_op_t               i_kind,
    input  logic [AMT_W-1:0]      i_amount,
    output logic [WORD_WIDTH-1:0] o_shifted
);

    // Rotations take the low word of the doubled value shifted right.
    logic [WORD_WIDTH-1:0] w_rot_r;
    logic [WORD_WIDTH-1:0] w_rot_l;

    assign w_rot_r = WORD_WIDTH'({i_value, i_value} >> i_amount);
    assign w_rot_l = WORD_WIDTH'({i_value, i_value} >> (WORD_WIDTH - int'(i_amount)));

    always_comb begin
        o_shifted = i_value;
        case (i_kind)
            OP_LSL:  o_shifted = i_value << i_amount;
            OP_LSR:  o_shifted = i_value >> i_amount;
            OP_ASR:  o_shifted = $unsigned($signed(i_value) >>> i_amount);
            OP_CSL:  o_shifted = w_rot_l;
            OP_CSR:  o_shifted = w_rot_r;
            default: o_shifted = i_value;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_unit
// Purpose  : Handshaked sequential ALU with carry flag, multi-cycle shifts and
//            an optional shift-add multiplier enabled by ALU_UNIT_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int DC_COUNT   = 4,
    parameter int SHIFT_STEP = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [4:0]                          op,
    input  logic [$clog2(DC_COUNT)-1:0]         dc_sel,
    input  logic [WORD_WIDTH-1:0]               top,
    input  logic [WORD_WIDTH-1:0]               second,
    input  logic [DC_COUNT-1:0][WORD_WIDTH-1:0] dc_vals,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WORD_WIDTH-1:0]               result,
    output logic                                carry
);

    localparam int AMT_W = $clog2(WORD_WIDTH);
    localparam int CNT_W = AMT_W + 1;

    alu_state_t            r_state;
    alu_op_t               r_kind;
    logic [WORD_WIDTH-1:0] r_value;
    logic [WORD_WIDTH-1:0] r_result;
    logic [CNT_W-1:0]      r_remaining;
    logic                  r_out_valid;
    logic                  r_carry;

    logic                  w_accept;
    logic [AMT_W-1:0]      w_amt;
    logic [AMT_W-1:0]      w_step;
    logic [WORD_WIDTH-1:0] w_shifted;
    logic [WORD_WIDTH-1:0] w_add_a;
    logic [WORD_WIDTH-1:0] w_add_b;
    logic                  w_add_cin;
    logic [WORD_WIDTH:0]   w_sum;

    assign in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign w_amt     = second[AMT_W-1:0];

    // SHIFT_STEP may equal WORD_WIDTH; remaining is then always below it.
    always_comb begin
        if (r_remaining < CNT_W'(SHIFT_STEP)) begin
            w_step = AMT_W'(r_remaining);
        end else begin
            w_step = AMT_W'(SHIFT_STEP);
        end
    end

    alu_shift_step #(
        .WORD_WIDTH (WORD_WIDTH),
        .AMT_W      (AMT_W)
    ) u_shift_step (
        .i_value    (r_value),
        .i_kind     (r_kind),
        .i_amount   (w_step),
        .o_shifted  (w_shifted)
    );

    always_comb begin
        w_add_a   = second;
        w_add_b   = top;
        w_add_cin = 1'b0;
        case (op)
            OP_ADDC:   w_add_cin = r_carry;
            OP_SUB:    begin w_add_a = ~second; w_add_cin = 1'b1; end
            OP_SUBC:   begin w_add_a = ~second; w_add_cin = r_carry; end
            OP_INC:    begin w_add_a = '0; w_add_cin = 1'b1; end
            OP_DEC:    w_add_a = '1;
            OP_CARRY:  begin w_add_a = '0; w_add_cin = r_carry; end
            OP_BORROW: begin w_add_a = '1; w_add_cin = r_carry; end
            OP_ADDZ:   w_add_a = dc_vals[dc_sel];
            default:   w_add_cin = 1'b0;
        endcase
        w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WORD_WIDTH{1'b0}}, w_add_cin};
    end

`ifdef ALU_UNIT_MUL_EN
    logic [WORD_WIDTH-1:0] r_acc;
    logic [WORD_WIDTH-1:0] r_mplier;
    logic [WORD_WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_value : '0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_kind      <= OP_ADD;
            r_value     <= '0;
            r_result    <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
`ifdef ALU_UNIT_MUL_EN
            r_acc       <= '0;
            r_mplier    <= '0;
`endif
        end else begin
            // A result write later in this block overrides the handshake clear.
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_kind  <= alu_op_t'(op);
                        r_value <= top;
                        case (op)
                            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_INC,
                            OP_DEC, OP_CARRY, OP_BORROW, OP_ADDZ: begin
                                r_result    <= w_sum[WORD_WIDTH-1:0];
                                r_carry     <= w_sum[WORD_WIDTH];
                                r_out_valid <= 1'b1;
                            end
                            OP_AND: begin
                                r_result    <= second & top;
                                r_out_valid <= 1'b1;
                            end
                            OP_OR: begin
                                r_result    <= second | top;
                                r_out_valid <= 1'b1;
                            end
                            OP_XOR: begin
                                r_result    <= second ^ top;
                                r_out_valid <= 1'b1;
                            end
                            OP_LSL, OP_LSR, OP_ASR, OP_CSL, OP_CSR: begin
                                if (w_amt == '0) begin
                                    r_result    <= top;
                                    r_out_valid <= 1'b1;
                                end else begin
                                    r_remaining <= CNT_W'(w_amt);
                                    r_state     <= ST_SHIFT;
                                end
                            end
`ifdef ALU_UNIT_MUL_EN
                            OP_MUL: begin
                                r_acc       <= '0;
                                r_mplier    <= second;
                                r_remaining <= CNT_W'(WORD_WIDTH);
                                r_state     <= ST_MUL;
                            end
`endif
                            default: begin
                                r_result    <= '0;
                                r_out_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    r_value     <= w_shifted;
                    r_remaining <= r_remaining - CNT_W'(w_step);
                    if (r_remaining == CNT_W'(w_step)) begin
                        r_result    <= w_shifted;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
`ifdef ALU_UNIT_MUL_EN
                ST_MUL: begin
                    r_acc       <= w_acc_next;
                    r_value     <= r_value << 1;
                    r_mplier    <= r_mplier >> 1;
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        r_result    <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_unit
// Purpose  : Scoreboard testbench for alu_unit (WORD_WIDTH 32, SHIFT_STEP 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_unit;
    import alu_unit_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [1:0]       dc_sel;
    logic [31:0]      top;
    logic [31:0]      second;
    logic [3:0][31:0] dc_vals;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic             carry;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;

    alu_unit #(
        .WORD_WIDTH (32),
        .DC_COUNT   (4),
        .SHIFT_STEP (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .dc_sel     (dc_sel),
        .top        (top),
        .second     (second),
        .dc_vals    (dc_vals),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry      (carry)
    );

    always #5 clk = ~clk;

    // Scoreboard: each negedge with valid&&ready is exactly one transfer.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got result=%h carry=%b, none expected", result, carry);
            end else begin
                exp_e = exp_q.pop_front();
                if (result !== exp_e[31:0]) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", result, exp_e[31:0]);
                end
                checks++;
                if (carry !== exp_e[32]) begin
                    errors++;
                    $display("FAIL carry: got %b expected %b (result %h)", carry, exp_e[32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] s, input logic [31:0] t,
                         input logic [1:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL issue_timeout: in_ready=%b expected 1 within 100 cycles", in_ready);
        end
        in_valid = 1'b1; op = o; second = s; top = t; dc_sel = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || carry !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid=%b result=%h carry=%b ready=%b expected 0/0/0/1",
                     out_valid, result, carry, in_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        exp_q.push_back({1'b1, 32'h0000_0000});
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 2'd0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency: out_valid=%b expected 1 one cycle after accept", out_valid);
        end
        exp_q.push_back({1'b0, 32'h0000_0001});
        issue(OP_ADDC, 32'h0, 32'h0, 2'd0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL addc_latency: out_valid=%b expected 1", out_valid);
        end
    endtask

    task automatic test_sub_addz();
        exp_q.push_back({1'b0, 32'hFFFF_FFFE});
        issue(OP_SUB, 32'h5, 32'h3, 2'd0);
        exp_q.push_back({1'b0, 32'h0000_0030});
        issue(OP_ADDZ, 32'hABCD, 32'h20, 2'd2);
    endtask

    task automatic test_shift();
        int bad;
        exp_q.push_back({1'b1, 32'h0});
        issue(OP_INC, 32'h0, 32'hFFFF_FFFF, 2'd0);
        exp_q.push_back({1'b1, 32'h8000_0000});
        issue(OP_LSL, 32'd31, 32'h1, 2'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lsl_busy: %0d busy cycles had in_ready/out_valid high, expected 0", bad);
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lsl_latency: valid=%b ready=%b expected 1/1 at N+5", out_valid, in_ready);
        end
        exp_q.push_back({1'b1, 32'hF800_0000});
        issue(OP_ASR, 32'd4, 32'h8000_0000, 2'd0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL asr_early: out_valid=%b expected 0 at N+1", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL asr_latency: out_valid=%b expected 1 at N+2", out_valid);
        end
        exp_q.push_back({1'b1, 32'h0000_0003});
        issue(OP_CSL, 32'd1, 32'h8000_0001, 2'd0);
        exp_q.push_back({1'b1, 32'h1234_5678});
        issue(OP_CSR, 32'h20, 32'h1234_5678, 2'd0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_shift_latency: out_valid=%b expected 1 at N+1", out_valid);
        end
        exp_q.push_back({1'b1, 32'h8123_4567});
        issue(OP_CSR, 32'd4, 32'h1234_5678, 2'd0);
        exp_q.push_back({1'b1, 32'h000F_0000});
        issue(OP_LSR, 32'd12, 32'hF000_0000, 2'd0);
    endtask

    task automatic test_backpressure();
        int bad;
        while (!in_ready) begin
            @(posedge clk); #1;
        end
        drain();
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 32'h0FF0_0FF0});
        issue(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd0);
        in_valid = 1'b1; op = OP_AND; second = 32'hF0F0_F0F0; top = 32'hFF00_FF00;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b1 || result !== 32'h0FF0_0FF0 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d stalled cycles lost the held result or accepted, expected 0", bad);
        end
        exp_q.push_back({1'b1, 32'hF000_F000});
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b expected 1 after pending accept", out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int bad;
        exp_q.push_back({1'b1, 32'h0});
        issue(OP_INC, 32'h0, 32'hFFFF_FFFF, 2'd0);
        issue(OP_CSR, 32'd20, 32'hA5A5_A5A5, 2'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || carry !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset: valid=%b carry=%b result=%h expected 0/0/0", out_valid, carry, result);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_result: %0d cycles showed a result or busy, expected 0", bad);
        end
    endtask

    task automatic test_mul();
`ifdef ALU_UNIT_MUL_EN
        int bad;
        exp_q.push_back({1'b0, 32'h0001_0000});
        issue(OP_MUL, 32'h0003_0001, 32'h0001_0000, 2'd0);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mul_busy: %0d multiply cycles not busy, expected 0", bad);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mul_latency: out_valid=%b expected 1 at N+33", out_valid);
        end
`else
        exp_q.push_back({1'b0, 32'h0});
        issue(OP_MUL, 32'h0003_0001, 32'h0001_0000, 2'd0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mul_unknown_latency: out_valid=%b expected 1 at N+1", out_valid);
        end
`endif
    endtask

    task automatic test_unknown();
        exp_q.push_back({1'b1, 32'h4});
        issue(OP_DEC, 32'h0, 32'h5, 2'd0);
        exp_q.push_back({1'b1, 32'h0});
        issue(5'd31, 32'h1234, 32'h5678, 2'd0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL unknown_latency: out_valid=%b expected 1", out_valid);
        end
        exp_q.push_back({1'b1, 32'h0});
        issue(OP_BORROW, 32'h0, 32'h0, 2'd0);
        exp_q.push_back({1'b1, 32'h0});
        issue(OP_SUBC, 32'h1, 32'h1, 2'd0);
        exp_q.push_back({1'b1, 32'hF0F0_FFFF});
        issue(OP_OR, 32'hF0F0_F0F0, 32'h0000_FFFF, 2'd0);
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ops  [4] = '{OP_ADD, OP_ADDC, OP_CARRY, OP_AND};
        logic [31:0] secs [4] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFF};
        logic [31:0] tops [4] = '{32'h2, 32'h0, 32'h5, 32'h1234};
        logic [32:0] exps [4] = '{{1'b1, 32'h1}, {1'b0, 32'h1}, {1'b0, 32'h5}, {1'b0, 32'h34}};
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b1) bad++;
            exp_q.push_back(exps[i]);
            in_valid = 1'b1; op = ops[i]; second = secs[i]; top = tops[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL back_to_back: in_ready low on %0d of 4 cycles, expected 0", bad);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 5'd0; dc_sel = 2'd0; top = 32'h0; second = 32'h0;
        dc_vals[0] = 32'hDEAD_0000; dc_vals[1] = 32'hDEAD_0001;
        dc_vals[2] = 32'h0000_0010; dc_vals[3] = 32'hDEAD_0003;
        test_reset();
        test_add();
        test_sub_addz();
        test_shift();
        test_backpressure();
        test_reset_abort();
        test_mul();
        test_unknown();
        test_back_to_back();
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
